// File: rtl/nios_debug_slave_sysclk_gen2.sv
// nios_debug_slave_sysclk_gen2
// System-clock half of the Nios II JTAG debug slave. It synchronises the
// TCK-side update-IR and exit1-DR event levels into clk and captures the
// instruction register and the DR shift register. Each completed DR scan is
// presented as one action on a valid/ready handshake. DR events that arrive
// while the consumer is busy are counted in a saturating overrun counter.
//
// Handshake: an action is offered while act_valid is high and is consumed on
// any rising edge where act_valid && act_ready. While act_valid is high,
// act_ir, act_take and jdo are held stable.
//
// Optional build macro: DEBUG_SLAVE_SYNC3_EN selects 3-flop synchronisers.
// When it is undefined, the synchronisers are 2 flops deep.
// The FSM state is visible directly on act_valid (IDLE=0, PENDING=1).
module nios_debug_slave_sysclk_gen2 #(
    parameter int IR_WIDTH      = 2,
    parameter int DR_WIDTH      = 38,
    parameter int OVR_CNT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic [DR_WIDTH-1:0]      sr,
    input  logic                     vs_uir,
    input  logic                     vs_e1dr,
    input  logic                     act_ready,
    input  logic                     clr_ovr,
    output logic [IR_WIDTH-1:0]      ir_q,
    output logic                     uir_pulse,
    output logic [DR_WIDTH-1:0]      jdo,
    output logic                     act_valid,
    output logic [IR_WIDTH-1:0]      act_ir,
    output logic                     act_take,
    output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
);

`ifdef DEBUG_SLAVE_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_DEPTH-1:0]    r_uir_sync;
    logic [SYNC_DEPTH-1:0]    r_e1dr_sync;
    logic                     r_uir_hist;
    logic                     r_e1dr_hist;
    logic                     w_uir_ev;
    logic                     w_dr_ev;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_act_valid;
    logic                     w_load;
    logic                     w_ovr;

    logic [IR_WIDTH-1:0]      w_ir_eff;
    logic [IR_WIDTH-1:0]      r_ir_q;
    logic                     r_uir_pulse;
    logic [DR_WIDTH-1:0]      r_jdo;
    logic [IR_WIDTH-1:0]      r_act_ir;
    logic                     r_act_take;
    logic [OVR_CNT_WIDTH-1:0] r_ovr_cnt;

    // Synchronise both event levels and keep one history flop behind each chain.
    // The history flops reset to 0, so a level that is already high when reset
    // is released is seen as a fresh rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uir_sync  <= '0;
            r_e1dr_sync <= '0;
            r_uir_hist  <= 1'b0;
            r_e1dr_hist <= 1'b0;
        end else begin
            r_uir_sync  <= {r_uir_sync[SYNC_DEPTH-2:0], vs_uir};
            r_e1dr_sync <= {r_e1dr_sync[SYNC_DEPTH-2:0], vs_e1dr};
            r_uir_hist  <= r_uir_sync[SYNC_DEPTH-1];
            r_e1dr_hist <= r_e1dr_sync[SYNC_DEPTH-1];
        end
    end

    assign w_uir_ev = r_uir_sync[SYNC_DEPTH-1] & ~r_uir_hist;
    assign w_dr_ev  = r_e1dr_sync[SYNC_DEPTH-1] & ~r_e1dr_hist;

    // Update-IR is ordered before update-DR, so a coincident IR update is used
    // for the action.
    assign w_ir_eff = w_uir_ev ? ir_in : r_ir_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: stay PENDING when a handshake and a new DR event coincide.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_dr_ev) w_state_nxt = ST_PENDING;
            ST_PENDING: if (act_ready && !w_dr_ev) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: decide whether a DR event loads a new action or is dropped.
    always_comb begin
        w_act_valid = (r_state == ST_PENDING);
        w_load      = w_dr_ev && (!w_act_valid || act_ready);
        w_ovr       = w_dr_ev && w_act_valid && !act_ready;
    end

    // Capture the instruction and produce the one-cycle update strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_q      <= '0;
            r_uir_pulse <= 1'b0;
        end else begin
            r_uir_pulse <= w_uir_ev;
            if (w_uir_ev) begin
                r_ir_q <= ir_in;
            end
        end
    end

    // Capture the action payload only when the event is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jdo      <= '0;
            r_act_ir   <= '0;
            r_act_take <= 1'b0;
        end else if (w_load) begin
            r_jdo      <= sr;
            r_act_ir   <= w_ir_eff;
            r_act_take <= sr[DR_WIDTH-1];
        end
    end

    // Saturating overrun counter; a clear that coincides with an overrun
    // leaves that overrun counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr_cnt <= '0;
        end else if (clr_ovr) begin
            r_ovr_cnt <= w_ovr ? OVR_CNT_WIDTH'(1) : '0;
        end else if (w_ovr && !(&r_ovr_cnt)) begin
            r_ovr_cnt <= r_ovr_cnt + OVR_CNT_WIDTH'(1);
        end
    end

    assign ir_q        = r_ir_q;
    assign uir_pulse   = r_uir_pulse;
    assign jdo         = r_jdo;
    assign act_valid   = w_act_valid;
    assign act_ir      = r_act_ir;
    assign act_take    = r_act_take;
    assign overrun_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_nios_debug_slave_sysclk_gen2.sv
// Testbench for nios_debug_slave_sysclk_gen2 (default parameters).
// Stimulus pushes expected actions and instructions into queues; a monitor
// pops and compares whenever the DUT presents a new action or an IR strobe.
module tb_nios_debug_slave_sysclk_gen2;

`ifdef DEBUG_SLAVE_SYNC3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int HOLD = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir;
    logic        vs_e1dr;
    logic        act_ready;
    logic        clr_ovr;
    logic [1:0]  ir_q;
    logic        uir_pulse;
    logic [37:0] jdo;
    logic        act_valid;
    logic [1:0]  act_ir;
    logic        act_take;
    logic [3:0]  overrun_cnt;

    logic [40:0] exp_q[$];
    logic [1:0]  exp_ir_q[$];
    logic [1:0]  m_ir;
    int          n_cmp  = 0;
    int          n_fail = 0;

    nios_debug_slave_sysclk_gen2 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ir_in       (ir_in),
        .sr          (sr),
        .vs_uir      (vs_uir),
        .vs_e1dr     (vs_e1dr),
        .act_ready   (act_ready),
        .clr_ovr     (clr_ovr),
        .ir_q        (ir_q),
        .uir_pulse   (uir_pulse),
        .jdo         (jdo),
        .act_valid   (act_valid),
        .act_ir      (act_ir),
        .act_take    (act_take),
        .overrun_cnt (overrun_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Monitor: a new action is presented when act_valid is high and either it
    // was low on the previous sample or a handshake completed in between.
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (act_valid && (!prev_valid || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_action", 64'({act_ir, act_take, jdo}), 64'h0);
                end else begin
                    check("action", 64'({act_ir, act_take, jdo}), 64'(exp_q.pop_front()));
                end
            end
            if (uir_pulse) begin
                if (exp_ir_q.size() == 0) begin
                    check("unexpected_uir_pulse", 64'(ir_q), 64'hF);
                end else begin
                    check("ir_q", 64'(ir_q), 64'(exp_ir_q.pop_front()));
                end
            end
            prev_valid = act_valid;
            prev_hs    = act_valid && act_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_action(input logic [37:0] val);
        exp_q.push_back({m_ir, val[37], val});
    endtask

    // One complete DR event honouring the minimum high and low times.
    task automatic dr_event(input logic [37:0] val, input bit accept);
        step();
        sr      = val;
        vs_e1dr = 1'b1;
        if (accept) push_action(val);
        repeat (HOLD) step();
        vs_e1dr = 1'b0;
        repeat (HOLD) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_act_valid"}, 64'(act_valid), 64'h0);
        check({tag, "_jdo"}, 64'(jdo), 64'h0);
        check({tag, "_act_ir"}, 64'(act_ir), 64'h0);
        check({tag, "_act_take"}, 64'(act_take), 64'h0);
        check({tag, "_ir_q"}, 64'(ir_q), 64'h0);
        check({tag, "_uir_pulse"}, 64'(uir_pulse), 64'h0);
        check({tag, "_overrun_cnt"}, 64'(overrun_cnt), 64'h0);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        ir_in     = '0;
        sr        = '0;
        vs_uir    = 1'b0;
        vs_e1dr   = 1'b0;
        act_ready = 1'b1;
        clr_ovr   = 1'b0;
        m_ir      = '0;

        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Update-IR with latency and one-cycle strobe checks
        ir_in  = 2'b10;
        vs_uir = 1'b1;
        m_ir   = 2'b10;
        exp_ir_q.push_back(2'b10);
        repeat (LAT) step();
        check("uir_early", 64'(uir_pulse), 64'h0);
        step();
        check("uir_on_time", 64'(uir_pulse), 64'h1);
        check("ir_q_direct", 64'(ir_q), 64'h2);
        step();
        check("uir_one_cycle", 64'(uir_pulse), 64'h0);
        repeat (HOLD) step();
        vs_uir = 1'b0;
        repeat (HOLD) step();

        // First DR action with latency check
        sr      = 38'h20_1234_5678;
        vs_e1dr = 1'b1;
        push_action(38'h20_1234_5678);
        repeat (LAT) step();
        check("dr_early", 64'(act_valid), 64'h0);
        step();
        check("dr_on_time", 64'(act_valid), 64'h1);
        check("dr_act_take", 64'(act_take), 64'h1);
        check("dr_act_ir", 64'(act_ir), 64'h2);
        repeat (HOLD) step();
        vs_e1dr = 1'b0;
        repeat (HOLD) step();

        // Busy consumer: second event is dropped
        act_ready = 1'b0;
        dr_event(38'h15_5555_5555, 1'b1);
        dr_event(38'h2A_AAAA_AAAA, 1'b0);
        check("drop_jdo_kept", 64'(jdo), 64'h15_5555_5555);
        check("drop_take_kept", 64'(act_take), 64'h0);
        check("drop_ovr1", 64'(overrun_cnt), 64'h1);
        act_ready = 1'b1;
        step();
        check("valid_fall", 64'(act_valid), 64'h0);
        repeat (2) step();

        // Saturation of the overrun counter
        act_ready = 1'b0;
        dr_event(38'h3C_0F0F_0F0F, 1'b1);
        for (int i = 0; i < 19; i++) dr_event(38'(i), 1'b0);
        check("ovr_sat", 64'(overrun_cnt), 64'hF);
        check("sat_jdo_kept", 64'(jdo), 64'h3C_0F0F_0F0F);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clear", 64'(overrun_cnt), 64'h0);

        // Clear coinciding with an overrun
        sr      = 38'h01_0000_0001;
        vs_e1dr = 1'b1;
        repeat (LAT) step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clear_with_overrun", 64'(overrun_cnt), 64'h1);
        repeat (HOLD) step();
        vs_e1dr = 1'b0;
        repeat (HOLD) step();
        act_ready = 1'b1;
        repeat (2) step();

        // Coincident update-IR and exit1-DR
        ir_in   = 2'b01;
        sr      = 38'h0C_AFE0_1234;
        vs_uir  = 1'b1;
        vs_e1dr = 1'b1;
        m_ir    = 2'b01;
        exp_ir_q.push_back(2'b01);
        push_action(38'h0C_AFE0_1234);
        repeat (HOLD) step();
        vs_uir  = 1'b0;
        vs_e1dr = 1'b0;
        repeat (HOLD) step();

        // Reload while pending: handshake and new event on the same edge
        act_ready = 1'b0;
        dr_event(38'h11_1111_1111, 1'b1);
        sr      = 38'h22_2222_2222;
        vs_e1dr = 1'b1;
        push_action(38'h22_2222_2222);
        repeat (LAT) step();
        act_ready = 1'b1;
        step();
        check("reload_valid", 64'(act_valid), 64'h1);
        check("reload_jdo", 64'(jdo), 64'h22_2222_2222);
        step();
        check("reload_then_idle", 64'(act_valid), 64'h0);
        repeat (HOLD) step();
        vs_e1dr = 1'b0;
        repeat (HOLD) step();

        // Reset while pending, released with the event level still high
        act_ready = 1'b0;
        sr        = 38'h3F_FFFF_0000;
        vs_e1dr   = 1'b1;
        push_action(38'h3F_FFFF_0000);
        repeat (LAT + 2) step();
        check("pending_before_reset", 64'(act_valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_ir      = '0;
        act_ready = 1'b1;
        repeat (2) step();
        push_action(38'h3F_FFFF_0000);
        reset_n = 1'b1;
        repeat (LAT) step();
        check("post_reset_early", 64'(act_valid), 64'h0);
        step();
        check("post_reset_on_time", 64'(act_valid), 64'h1);
        check("post_reset_act_ir", 64'(act_ir), 64'h0);
        repeat (HOLD) step();
        vs_e1dr = 1'b0;
        repeat (HOLD) step();

        // Drain
        check("exp_q_empty", 64'(exp_q.size()), 64'h0);
        check("exp_ir_q_empty", 64'(exp_ir_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
